// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - keypad operand entry FSM building a decimal A/B operand pair
// Optional feature macro: KEY_EDGE_DETECT_EN (events on the 0->1 edge of key_valid only)
module operand_entry #(
   parameter int MAX_DIGITS = 3,
   parameter int OP_W       = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            key_valid,
   input  logic [3:0]      key_code,
   output logic [OP_W-1:0] op_a,
   output logic [OP_W-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [OP_W-1:0] disp_value,
   output logic [1:0]      entry_sel
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

   typedef enum logic [1:0] {
      S_A   = 2'b00,
      S_B   = 2'b01,
      S_OUT = 2'b10
   } state_t;

   state_t            state_q, state_d;
   logic [OP_W-1:0]   acc_a_q, acc_a_d;
   logic [OP_W-1:0]   acc_b_q, acc_b_d;
   logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
   logic              out_valid_q, out_valid_d;
   logic [OP_W-1:0]   disp_q, disp_d;
   logic              key_ev;
   logic              is_digit;

`ifdef KEY_EDGE_DETECT_EN
   logic key_valid_q;

   // Remember last cycle's key_valid so a held key produces one event only
   always_ff @(posedge clk) begin
      if (!rst) key_valid_q <= 1'b0;
      else      key_valid_q <= key_valid;
   end

   assign key_ev = key_valid && !key_valid_q;
`else
   assign key_ev = key_valid;
`endif

   assign is_digit = (key_code <= 4'd9);

   // Shift-and-add times ten, truncated to the operand width
   function automatic logic [OP_W-1:0] mul10_add(input logic [OP_W-1:0] x, input logic [3:0] d);
      return (x << 3) + (x << 1) + OP_W'(d);
   endfunction

   // Next-state and datapath decode for the entry sequence
   always_comb begin
      state_d     = state_q;
      acc_a_d     = acc_a_q;
      acc_b_d     = acc_b_q;
      cnt_a_d     = cnt_a_q;
      cnt_b_d     = cnt_b_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_A: begin
            if (key_ev) begin
               if (is_digit) begin
                  if (cnt_a_q < MAX_CNT) begin
                     acc_a_d = mul10_add(acc_a_q, key_code);
                     cnt_a_d = cnt_a_q + CNT_W'(1);
                  end
               end else if (key_code == 4'hA) begin
                  state_d = S_B;
               end else if (key_code == 4'hB) begin
                  acc_a_d = '0;
                  acc_b_d = '0;
                  cnt_a_d = '0;
                  cnt_b_d = '0;
                  state_d = S_A;
               end
            end
         end
         S_B: begin
            if (key_ev) begin
               if (is_digit) begin
                  if (cnt_b_q < MAX_CNT) begin
                     acc_b_d = mul10_add(acc_b_q, key_code);
                     cnt_b_d = cnt_b_q + CNT_W'(1);
                  end
               end else if (key_code == 4'hA) begin
                  state_d     = S_OUT;
                  out_valid_d = 1'b1;
               end else if (key_code == 4'hB) begin
                  acc_a_d = '0;
                  acc_b_d = '0;
                  cnt_a_d = '0;
                  cnt_b_d = '0;
                  state_d = S_A;
               end
            end
         end
         S_OUT: begin
            // Keys are ignored here; only the handshake releases the pair
            if (out_valid_q && out_ready) begin
               acc_a_d     = '0;
               acc_b_d     = '0;
               cnt_a_d     = '0;
               cnt_b_d     = '0;
               out_valid_d = 1'b0;
               state_d     = S_A;
            end
         end
         default: begin
            state_d     = S_A;
            out_valid_d = 1'b0;
         end
      endcase
      disp_d = (state_d == S_A) ? acc_a_d : acc_b_d;
   end

   // State, accumulators and registered outputs; reset wins over everything
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_A;
         acc_a_q     <= '0;
         acc_b_q     <= '0;
         cnt_a_q     <= '0;
         cnt_b_q     <= '0;
         out_valid_q <= 1'b0;
         disp_q      <= '0;
      end else begin
         state_q     <= state_d;
         acc_a_q     <= acc_a_d;
         acc_b_q     <= acc_b_d;
         cnt_a_q     <= cnt_a_d;
         cnt_b_q     <= cnt_b_d;
         out_valid_q <= out_valid_d;
         disp_q      <= disp_d;
      end
   end

   assign op_a       = acc_a_q;
   assign op_b       = acc_b_q;
   assign out_valid  = out_valid_q;
   assign disp_value = disp_q;
   assign entry_sel  = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - directed vector bench for operand_entry
module tb_operand_entry;

   localparam int OP_W = 10;

   logic            clk;
   logic            rst;
   logic            key_valid;
   logic [3:0]      key_code;
   logic [OP_W-1:0] op_a;
   logic [OP_W-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [OP_W-1:0] disp_value;
   logic [1:0]      entry_sel;

   int n_cmp = 0;
   int n_bad = 0;

   operand_entry #(.MAX_DIGITS(3), .OP_W(OP_W)) dut (
      .clk(clk),
      .rst(rst),
      .key_valid(key_valid),
      .key_code(key_code),
      .op_a(op_a),
      .op_b(op_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .disp_value(disp_value),
      .entry_sel(entry_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic            rst_n;
      logic            kv;
      logic [3:0]      code;
      logic            rdy;
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
      logic            v;
      logic [OP_W-1:0] d;
      logic [1:0]      sel;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input int rst_n, input int kv, input int code, input int rdy,
                               input int a, input int b, input int v, input int d, input int sel);
      vec_t r;
      r.rst_n = rst_n[0];
      r.kv    = kv[0];
      r.code  = code[3:0];
      r.rdy   = rdy[0];
      r.a     = a[OP_W-1:0];
      r.b     = b[OP_W-1:0];
      r.v     = v[0];
      r.d     = d[OP_W-1:0];
      r.sel   = sel[1:0];
      return r;
   endfunction

   task automatic check(input string name, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                        input logic v, input logic [OP_W-1:0] d, input logic [1:0] sel);
      n_cmp++;
      if (op_a !== a || op_b !== b || out_valid !== v || disp_value !== d || entry_sel !== sel) begin
         n_bad++;
         $display("FAIL %s: got a=%0d b=%0d v=%0b disp=%0d sel=%0d, want a=%0d b=%0d v=%0b disp=%0d sel=%0d",
                  name, op_a, op_b, out_valid, disp_value, entry_sel, a, b, v, d, sel);
      end
   endtask

   task automatic idle();
      rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; out_ready = 1'b0;
   endtask

   // One row: drive, clock, compare, then one quiet cycle so keys are separate pulses
   task automatic apply(input vec_t t, input int idx);
      rst = t.rst_n; key_valid = t.kv; key_code = t.code; out_ready = t.rdy;
      @(posedge clk); #1;
      check($sformatf("row%0d", idx), t.a, t.b, t.v, t.d, t.sel);
      idle();
      @(posedge clk); #1;
   endtask

   initial begin
      idle();
      // reset
      vecs.push_back(mk(0,0,0,0,   0,  0,0,  0,0));
      // 1,2,3,A,4,5,A
      vecs.push_back(mk(1,1,1,0,   1,  0,0,  1,0));
      vecs.push_back(mk(1,1,2,0,  12,  0,0, 12,0));
      vecs.push_back(mk(1,1,3,0, 123,  0,0,123,0));
      vecs.push_back(mk(1,1,10,0,123,  0,0,  0,1));
      vecs.push_back(mk(1,1,4,0, 123,  4,0,  4,1));
      vecs.push_back(mk(1,1,5,0, 123, 45,0, 45,1));
      vecs.push_back(mk(1,1,10,0,123, 45,1, 45,2));
      // hold in S_OUT, keys 7,B,F ignored
      vecs.push_back(mk(1,0,0,0, 123, 45,1, 45,2));
      vecs.push_back(mk(1,1,7,0, 123, 45,1, 45,2));
      vecs.push_back(mk(1,1,11,0,123, 45,1, 45,2));
      vecs.push_back(mk(1,1,15,0,123, 45,1, 45,2));
      // handshake
      vecs.push_back(mk(1,0,0,1,   0,  0,0,  0,0));
      // out_ready ignored in S_A
      vecs.push_back(mk(1,1,1,1,   1,  0,0,  1,0));
      vecs.push_back(mk(1,1,11,0,  0,  0,0,  0,0));
      // 1,2,3,4 : fourth digit dropped; C ignored
      vecs.push_back(mk(1,1,1,0,   1,  0,0,  1,0));
      vecs.push_back(mk(1,1,2,0,  12,  0,0, 12,0));
      vecs.push_back(mk(1,1,3,0, 123,  0,0,123,0));
      vecs.push_back(mk(1,1,4,0, 123,  0,0,123,0));
      vecs.push_back(mk(1,1,12,0,123,  0,0,123,0));
      vecs.push_back(mk(1,1,10,0,123,  0,0,  0,1));
      vecs.push_back(mk(1,1,9,0, 123,  9,0,  9,1));
      vecs.push_back(mk(1,1,11,0,  0,  0,0,  0,0));
      // 9,A,7,B
      vecs.push_back(mk(1,1,9,0,   9,  0,0,  9,0));
      vecs.push_back(mk(1,1,10,0,  9,  0,0,  0,1));
      vecs.push_back(mk(1,1,7,0,   9,  7,0,  7,1));
      vecs.push_back(mk(1,1,11,0,  0,  0,0,  0,0));
      // 1,2,A,3 then reset with a simultaneous key
      vecs.push_back(mk(1,1,1,0,   1,  0,0,  1,0));
      vecs.push_back(mk(1,1,2,0,  12,  0,0, 12,0));
      vecs.push_back(mk(1,1,10,0, 12,  0,0,  0,1));
      vecs.push_back(mk(1,1,3,0,  12,  3,0,  3,1));
      vecs.push_back(mk(0,1,5,0,   0,  0,0,  0,0));
      // empty operands, key during handshake dropped
      vecs.push_back(mk(1,1,10,0,  0,  0,0,  0,1));
      vecs.push_back(mk(1,1,10,0,  0,  0,1,  0,2));
      vecs.push_back(mk(1,1,5,1,   0,  0,0,  0,0));
      vecs.push_back(mk(1,1,5,0,   5,  0,0,  5,0));
      vecs.push_back(mk(1,1,11,0,  0,  0,0,  0,0));
      // reset wins in S_OUT over the handshake
      vecs.push_back(mk(1,1,1,0,   1,  0,0,  1,0));
      vecs.push_back(mk(1,1,10,0,  1,  0,0,  0,1));
      vecs.push_back(mk(1,1,2,0,   1,  2,0,  2,1));
      vecs.push_back(mk(1,1,10,0,  1,  2,1,  2,2));
      vecs.push_back(mk(0,0,0,1,   0,  0,0,  0,0));
      // setup for the back-to-back hold sequence
      vecs.push_back(mk(1,1,8,0,   8,  0,0,  8,0));
      vecs.push_back(mk(1,1,10,0,  8,  0,0,  0,1));
      vecs.push_back(mk(1,1,10,0,  8,  0,1,  0,2));

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

      // five consecutive stalled cycles, with keys 7 and B mixed in
      for (int c = 0; c < 5; c++) begin
         idle();
         if (c == 1) begin key_valid = 1'b1; key_code = 4'h7; end
         if (c == 3) begin key_valid = 1'b1; key_code = 4'hB; end
         @(posedge clk); #1;
         check($sformatf("stall%0d", c), 8, 0, 1'b1, 0, 2'b10);
      end
      idle(); out_ready = 1'b1;
      @(posedge clk); #1;
      check("release", 0, 0, 1'b0, 0, 2'b00);
      idle(); out_ready = 1'b1;
      @(posedge clk); #1;
      check("ready_in_S_A", 0, 0, 1'b0, 0, 2'b00);

      // key_valid held high for four cycles with digit 5
      idle(); key_valid = 1'b1; key_code = 4'h5;
      repeat (4) @(posedge clk);
      #1; idle();
      @(posedge clk); #1;
`ifdef KEY_EDGE_DETECT_EN
      check("held_key", 5, 0, 1'b0, 5, 2'b00);
`else
      check("held_key", 555, 0, 1'b0, 555, 2'b00);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/operand_entry.md
OPERAND_ENTRY -- requirements
Module: operand_entry

Interface
REQ-001 The block SHALL take parameter MAX_DIGITS, default 3, meaning the maximum decimal digits accepted per operand.
REQ-002 The block SHALL take parameter OP_W, default 10, meaning the operand width in bits; it must be at least ceil(log2(10^MAX_DIGITS)).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-low reset sampled on the rising clk edge.
REQ-005 The block SHALL have port key_valid, input, 1, meaning a key is present on key_code.
REQ-006 The block SHALL have port key_code, input, 4, the keypad code: 0x0-0x9 digit, 0xA enter, 0xB clear, 0xC-0xF ignored.
REQ-007 The block SHALL have port op_a, output, OP_W, the binary value of operand A.
REQ-008 The block SHALL have port op_b, output, OP_W, the binary value of operand B.
REQ-009 The block SHALL have port out_valid, output, 1, meaning op_a/op_b form a completed pair.
REQ-010 The block SHALL have port out_ready, input, 1, meaning downstream accepts the pair.
REQ-011 The block SHALL have port disp_value, output, OP_W, the operand currently being edited: A in S_A, B in S_B, B in S_OUT.
REQ-012 The block SHALL have port entry_sel, output, 2, giving the state: 00 S_A, 01 S_B, 10 S_OUT.

Function
REQ-013 A key event SHALL be one clk cycle in which key_valid=1, with event qualification per REQ-027/028.
REQ-014 The FSM SHALL have exactly the states S_A, S_B and S_OUT, and all outputs SHALL be registered.
REQ-015 In S_A, a digit d with cnt_a<MAX_DIGITS SHALL update acc_a to acc_a*10+d (computed as (x<<3)+(x<<1)+d, truncated to OP_W) and increment cnt_a; with cnt_a=MAX_DIGITS the digit SHALL be dropped.
REQ-016 In S_A, 0xA SHALL move the FSM to S_B, including when cnt_a=0, in which case A=0.
REQ-017 In S_B, digits SHALL update acc_b/cnt_b by the rule in REQ-015, and 0xA SHALL move the FSM to S_OUT with out_valid=1 in the following cycle.
REQ-018 0xB in S_A or S_B SHALL clear acc_a, acc_b, cnt_a and cnt_b to 0 and move the FSM to S_A in the next cycle.
REQ-019 In S_OUT, out_valid SHALL stay 1 and op_a/op_b SHALL stay stable until the cycle in which out_valid&&out_ready.
REQ-020 On the cycle where out_valid&&out_ready, the next cycle SHALL have out_valid=0, the FSM in S_A, and all accumulators and counters at 0.
REQ-021 All key events, including 0xB, SHALL be ignored in S_OUT; a key arriving in the same cycle as the handshake SHALL be dropped.
REQ-022 Codes 0xC-0xF SHALL have no effect in any state.
REQ-023 Each update SHALL have 1-cycle latency: an event at edge N SHALL be reflected on op_*/disp_value/entry_sel after edge N.
REQ-024 out_ready SHALL be ignored outside S_OUT.

Reset
REQ-025 With rst=0 at a rising edge, after that edge the FSM SHALL be in S_A, and op_a, op_b, disp_value, cnt_a, cnt_b and out_valid SHALL be 0, with entry_sel=00.
REQ-026 Reset SHALL take priority over key events and the handshake in any state, including mid-entry and S_OUT.

Configuration
REQ-027 With macro KEY_EDGE_DETECT_EN defined, the block SHALL register key_valid, and an event SHALL occur only on its 0->1 transition, using key_code from that cycle; the edge register SHALL reset to 0.
REQ-028 With KEY_EDGE_DETECT_EN undefined, every cycle with key_valid=1 SHALL be an event, and upstream SHALL supply single-cycle pulses.

Verification
REQ-029 Keys 1,2,3,A,4,5,A with out_ready=0 SHALL give op_a=123, op_b=45, and out_valid=1 one cycle after the second A.
REQ-030 Keys 1,2,3,4 in S_A SHALL give disp_value=123, cnt_a=3, with the 4th digit dropped.
REQ-031 In S_OUT with out_ready low for 5 cycles plus keys 7,B, out_valid and operands SHALL hold; with out_ready then raised, the next cycle SHALL give entry_sel=00, op_a=op_b=0.
REQ-032 Keys 9,A,7,B SHALL return entry_sel=00 with op_a=op_b=disp_value=0.
REQ-033 rst=0 for 1 cycle during S_B with op_a=12 and op_b=3 SHALL zero all outputs, with entry_sel=00 after the edge.
REQ-034 key_valid held high for 4 cycles with code 5 SHALL give disp_value=5 with KEY_EDGE_DETECT_EN and 555 without it.
